// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- 16-bit program counter stage for the CS385 CPU.
//
// Holds the fetch address and computes the next one. The candidates are a
// sequential increment, a PC-relative branch and an absolute jump. A
// three-state control FSM (BOOT, RUN, HALTED) sequences start-up and halt.
// The pc output drives instruction memory and the IF/ID pipeline register.
//
// Parameters:
//   INC        sequential increment in bytes (16-bit instructions, byte
//              addressed)
//   RESET_VEC  PC value loaded by reset; bit 0 must be 0
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   stall        in   1   hold PC this cycle (hazard / memory wait)
//   halt         in   1   enter HALTED (HALT opcode decoded)
//   jump         in   1   load jump_target
//   jump_target  in  16   absolute target, bit 0 forced to 0
//   br_taken     in   1   take PC-relative branch
//   br_offset    in   8   signed branch offset in instruction words
//   pc           out 16   current fetch address (registered)
//   pc_plus      out 16   pc + INC (combinational, mod 2^16)
//   valid        out  1   pc is a valid fetch address (registered)
//   halted       out  1   FSM is in HALTED (registered)
//   link         out 16   return address of the last accepted jump
//                         (only when PC_LINK_EN is defined)
//
// Configuration macro: PC_LINK_EN adds the link register and link port.
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter logic [15:0] INC       = 16'd2,
    parameter logic [15:0] RESET_VEC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        br_taken,
    input  logic [7:0]  br_offset,
    output logic [15:0] pc,
    output logic [15:0] pc_plus,
    output logic        valid,
`ifdef PC_LINK_EN
    output logic [15:0] link,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] jump_pc;
    logic [15:0] br_pc;

    // All sums are 16 bits wide; carry out is dropped so wrap-around is silent.
    assign pc_plus = pc + INC;

    // Mask rather than slice so the ignored bit 0 is still consumed.
    assign jump_pc = jump_target & 16'hFFFE;

    // Offset is in instruction words: sign-extend, then scale by two bytes.
    assign br_pc = pc_plus + {{7{br_offset[7]}}, br_offset, 1'b0};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching real flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_BOOT;
            pc     <= RESET_VEC;
            valid  <= 1'b0;
            halted <= 1'b0;
`ifdef PC_LINK_EN
            link   <= 16'h0000;
`endif
        end else begin
            case (state)
                // One settling cycle after reset; requests are ignored here.
                ST_BOOT: begin
                    state <= ST_RUN;
                    valid <= 1'b1;
                end

                // Priority: halt > stall > jump > branch > increment.
                ST_RUN: begin
                    if (halt) begin
                        state  <= ST_HALTED;
                        valid  <= 1'b0;
                        halted <= 1'b1;
                    end else if (stall) begin
                        // Same address is re-fetched. A redirect arriving
                        // during a stall must be held by its requester.
                        pc <= pc;
                    end else if (jump) begin
                        pc <= jump_pc;
`ifdef PC_LINK_EN
                        link <= pc_plus;
`endif
                    end else if (br_taken) begin
                        pc <= br_pc;
                    end else begin
                        pc <= pc_plus;
                    end
                end

                // Frozen until reset; no input can leave this state.
                ST_HALTED: begin
                    state <= ST_HALTED;
                end

                default: begin
                    state  <= ST_BOOT;
                    valid  <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

16-bit program counter stage for the CS385 CPU. Holds the fetch address and computes the next one from sequential increment, PC-relative branch, or absolute jump. The PC is the upstream producer of the fetch address: its output drives instruction memory and the IF/ID 16-bit pipeline register. A small control FSM sequences boot, run and halt.

## Interface
- INC, 2: sequential increment in bytes; instructions are 16-bit, byte-addressed.
- RESET_VEC, 16'h0000: PC value loaded by reset; bit 0 must be 0.

- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset; one clock, no other clocks.
- STALL  input  1  hold PC this cycle (hazard or memory wait).
- HALT  input  1  enter HALTED state (HALT opcode decoded).
- JUMP  input  1  load JUMP_TARGET.
- JUMP_TARGET  input  16  absolute target; bit 0 ignored (forced to 0).
- BR_TAKEN  input  1  take PC-relative branch.
- BR_OFFSET  input  8  signed offset in instruction words.
- PC  output  16  current fetch address (registered).
- PC_PLUS  output  16  PC + INC, combinational, mod 2^16.
- VALID  output  1  PC is a valid fetch address this cycle (registered).
- HALTED  output  1  FSM in HALTED (registered).

## Operation
- FSM states: BOOT, RUN, HALTED.
  - BOOT: entered on reset. VALID=0, PC=RESET_VEC. Next edge -> RUN; PC unchanged.
  - RUN: VALID=1. PC updates per priority below. HALT=1 -> HALTED, PC held.
  - HALTED: VALID=0, HALTED=1, PC frozen. Only exit is reset.
- Next-PC priority in RUN (highest first): HALT, STALL, JUMP, BR_TAKEN, increment.
  - HALT: PC held.
  - STALL: PC held, VALID stays 1 (same address re-fetched). STALL overrides JUMP/BR_TAKEN, so the requester must hold them until STALL drops.
  - JUMP: PC <= {JUMP_TARGET[15:1], 1'b0}.
  - BR_TAKEN: PC <= PC + INC + (sign_ext16(BR_OFFSET) << 1).
  - else: PC <= PC + INC.
- Arithmetic: all sums 16-bit, carry discarded. Wrap-around is legal and silent: 16'hFFFE + 2 = 16'h0000.
- JUMP and BR_TAKEN asserted together: JUMP wins. Branch is dropped, not queued.
- Inputs other than RST_N are ignored in BOOT and HALTED.

## Timing
- Reset values: PC=RESET_VEC, VALID=0, HALTED=0, state=BOOT. Applied asynchronously on RST_N falling, independent of CLK. Held while RST_N=0.
- First rising edge with RST_N=1 -> RUN. VALID=1 one cycle after reset release.
- Redirect latency: JUMP/BR_TAKEN sampled at edge N; new PC visible after edge N. No bubble inserted by this block.
- HALT sampled at edge N: HALTED=1 and VALID=0 after edge N.
- Reset mid-operation: from any state, any cycle, outputs return to reset values immediately. A pending STALL/JUMP/BR_TAKEN is discarded.
- PC_PLUS follows PC combinationally within the same cycle.

## Configuration
- PC_LINK_EN: when defined, adds output LINK (16-bit, reset 16'h0000). LINK <= PC + INC on every accepted JUMP in RUN, i.e. JUMP=1, STALL=0, HALT=0. It holds otherwise, including across STALL and HALTED. It feeds the jal write-back path.
- Without PC_LINK_EN: no LINK port and no link register. All other behaviour is identical.

## Test plan
- Reset/boot: RST_N=0 then release, RESET_VEC=16'h0000 -> PC=0000, VALID=0 for one edge, then VALID=1. PC sequence 0000, 0002, 0004.
- Wrap: JUMP to 16'hFFFE, then free-run -> PC FFFE then 0000, no error flag, VALID=1 throughout.
- Branch: PC=0010, BR_TAKEN=1, BR_OFFSET=8'hFC (-4) -> PC=000A. Then BR_OFFSET=8'h7F at PC=0000 -> PC=0100.
- Priority: PC=0020, JUMP=1 JUMP_TARGET=1235, BR_TAKEN=1 -> PC=1234. Same stimulus with STALL=1 -> PC stays 0020, VALID=1. With PC_LINK_EN and STALL=0 -> LINK=0022.
- Halt: PC=0040, HALT=1 with JUMP=1 -> PC stays 0040, HALTED=1, VALID=0. Further JUMP/STALL have no effect for 10 cycles.
- Async reset mid-run: drop RST_N between edges while PC=0A00 -> PC=0000, VALID=0, HALTED=0 before the next edge. Re-run the boot sequence.
